// File: rtl/mem_stage_sram.sv
// MIPS memory stage: 32-bit loads/stores over a 16-bit asynchronous SRAM,
// each half-access held for WAIT_CYCLES clocks while ready freezes the pipeline.
module mem_stage_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Src2_Val,
  output logic [31:0] Mem_read_value,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_WE_N
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_lo_buf;
  logic [31:0] r_rd_val;
  logic        w_last;
  logic [16:0] w_word;

  assign w_last = (r_cnt == LAST_CNT);
  // Offset wraps modulo 2^32; only offset[18:2] selects the SRAM word.
  assign w_word = 17'((ALU_result - BASE_ADDR) >> 2);
  assign Mem_read_value = r_rd_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_lo_buf <= '0;
      r_rd_val <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (MEM_W_EN)      r_state <= S_WR_LO;
          else if (MEM_R_EN) r_state <= S_RD_LO;
        end
        S_RD_LO: begin
          if (w_last) begin
            r_lo_buf <= SRAM_DQ_IN;
            r_state  <= S_RD_HI;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RD_HI: begin
          if (w_last) begin
            r_rd_val <= {SRAM_DQ_IN, r_lo_buf};
            r_state  <= S_DONE;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR_LO: begin
          if (w_last) begin
            r_state <= S_WR_HI;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR_HI: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ready       = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_DQ_OUT = '0;
    SRAM_DQ_OE  = 1'b0;
    SRAM_WE_N   = 1'b1;
    case (r_state)
      S_IDLE:  ready = !(MEM_R_EN || MEM_W_EN);
      S_DONE:  ready = 1'b1;
      S_RD_LO: SRAM_ADDR = {w_word, 1'b0};
      S_RD_HI: SRAM_ADDR = {w_word, 1'b1};
      S_WR_LO: begin
        SRAM_ADDR   = {w_word, 1'b0};
        SRAM_DQ_OUT = Src2_Val[15:0];
        SRAM_DQ_OE  = 1'b1;
        SRAM_WE_N   = 1'b0;
      end
      S_WR_HI: begin
        SRAM_ADDR   = {w_word, 1'b1};
        SRAM_DQ_OUT = Src2_Val[31:16];
        SRAM_DQ_OE  = 1'b1;
        SRAM_WE_N   = 1'b0;
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: SRAM bus models, freeze-style request handling and a
// word-level reference memory; second instance exercises WAIT_CYCLES=1.
module tb_mem_stage_sram;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int W1 = 2;
  localparam int W2 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r, mem_w, mem_r2, mem_w2;
  logic [31:0] alu, src2, alu2, src22;
  logic [31:0] rdval, rdval2;
  logic        ready, ready2;
  logic [17:0] saddr, saddr2;
  logic [15:0] dq_out, dq_out2, dq_in, dq_in2;
  logic        oe, oe2, we_n, we_n2;

  logic [15:0] sram  [0:262143] = '{default: 16'h0000};
  logic [15:0] sram2 [0:262143] = '{default: 16'h0000};

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rdval, exp_rdval2;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_sram #(.BASE_ADDR(BASE), .WAIT_CYCLES(W1)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r), .MEM_W_EN(mem_w),
    .ALU_result(alu), .Src2_Val(src2), .Mem_read_value(rdval), .ready(ready),
    .SRAM_ADDR(saddr), .SRAM_DQ_OUT(dq_out), .SRAM_DQ_OE(oe),
    .SRAM_DQ_IN(dq_in), .SRAM_WE_N(we_n)
  );

  mem_stage_sram #(.BASE_ADDR(BASE), .WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r2), .MEM_W_EN(mem_w2),
    .ALU_result(alu2), .Src2_Val(src22), .Mem_read_value(rdval2), .ready(ready2),
    .SRAM_ADDR(saddr2), .SRAM_DQ_OUT(dq_out2), .SRAM_DQ_OE(oe2),
    .SRAM_DQ_IN(dq_in2), .SRAM_WE_N(we_n2)
  );

  // Asynchronous SRAM: reads follow the address, writes land while WE_N is low.
  assign dq_in  = sram[saddr];
  assign dq_in2 = sram2[saddr2];
  always @(negedge clk) if (!we_n)  sram[saddr]   <= dq_out;
  always @(negedge clk) if (!we_n2) sram2[saddr2] <= dq_out2;

  function automatic int unsigned word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (off % 32'd524288) / 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request (called just after a rising edge) and holds it until ready.
  task automatic access(input bit u, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data, input string tag);
    int zeros = 0;
    int welow = 0;
    int oehi  = 0;
    bit done  = 0;
    int w     = u ? W2 : W1;
    int unsigned wd = word_of(addr);
    if (u) begin mem_r2 = rd; mem_w2 = wr; alu2 = addr; src22 = data; end
    else   begin mem_r  = rd; mem_w  = wr; alu  = addr; src2  = data; end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (u ? ready2 : ready) done = 1;
      else begin
        zeros++;
        if (!(u ? we_n2 : we_n)) welow++;
        if (u ? oe2 : oe) oehi++;
      end
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stall"}, zeros, 1 + 2 * w);
    chk({tag, " we_low"}, welow, wr ? 2 * w : 0);
    chk({tag, " oe_high"}, oehi, wr ? 2 * w : 0);
    chk({tag, " we_done"}, 32'(u ? we_n2 : we_n), 32'd1);
    if (wr) begin
      if (!u) ref_mem[wd] = data;
      chk({tag, " hw_lo"}, u ? sram2[wd*2] : sram[wd*2], data[15:0]);
      chk({tag, " hw_hi"}, u ? sram2[wd*2+1] : sram[wd*2+1], data[31:16]);
    end else if (rd) begin
      if (u) exp_rdval2 = data;
      else   exp_rdval  = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
    end
    chk({tag, " rdval"}, u ? rdval2 : rdval, u ? exp_rdval2 : exp_rdval);
    @(posedge clk); #1;
    if (u) begin mem_r2 = 0; mem_w2 = 0; end
    else   begin mem_r  = 0; mem_w  = 0; end
  endtask

  initial begin
    logic [31:0] a, d;
    int unsigned sel;
    rst = 0; mem_r = 0; mem_w = 0; mem_r2 = 0; mem_w2 = 0;
    alu = '0; src2 = '0; alu2 = '0; src22 = '0;
    exp_rdval = '0; exp_rdval2 = '0;
    #3;
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst we_n", 32'(we_n), 32'd1);
    chk("rst oe", 32'(oe), 32'd0);
    chk("rst addr", 32'(saddr), 32'd0);
    chk("rst rdval", rdval, 32'd0);
    chk("rst rdval2", rdval2, 32'd0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    access(0, 0, 1, 32'd1028, 32'hDEADBEEF, "store1028");
    chk("store hw2", 32'(sram[2]), 32'h0000BEEF);
    chk("store hw3", 32'(sram[3]), 32'h0000DEAD);
    access(0, 1, 0, 32'd1028, 32'h0, "load1028");
    chk("load value", rdval, 32'hDEADBEEF);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle ready", 32'(ready), 32'd1);
      chk("idle we_n", 32'(we_n), 32'd1);
      chk("idle addr", 32'(saddr), 32'd0);
      chk("idle rdval", rdval, 32'hDEADBEEF);
    end
    @(posedge clk); #1;

    // Back-to-back: second request presented on the edge that leaves DONE.
    access(0, 0, 1, 32'd1024, 32'h0BADF00D, "prep1024");
    access(0, 1, 0, 32'd1024, 32'h0, "b2b_load");
    access(0, 0, 1, 32'd1032, 32'h13579BDF, "b2b_store");
    chk("b2b rdval kept", rdval, 32'h0BADF00D);
    @(negedge clk);
    chk("b2b idle ready", 32'(ready), 32'd1);
    chk("b2b idle we_n", 32'(we_n), 32'd1);
    @(posedge clk); #1;

    // Address boundaries: wrap below BASE, alias above 2^19, unaligned bytes.
    access(0, 0, 1, 32'd1020, 32'hCAFEF00D, "wrap_store");
    chk("wrap hw", 32'(sram[18'h3FFFE]), 32'h0000F00D);
    access(0, 1, 0, 32'd1020 + 32'd524288, 32'h0, "alias_load");
    access(0, 1, 0, 32'd1027, 32'h0, "unaligned_load");

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      a = BASE + 32'($urandom_range(0, 191));
      d = $urandom;
      access(0, sel != 1, sel == 1 || sel == 2, a, d, $sformatf("rnd%0d", i));
    end

    // Conflict resolves to a write; reset lands during WR_HI.
    mem_r = 1; mem_w = 1; alu = 32'd1224; src2 = 32'h12345678;
    repeat (4) @(negedge clk);
    chk("conf we_n", 32'(we_n), 32'd0);
    chk("conf addr", 32'(saddr), 32'd101);
    chk("conf lo", 32'(sram[100]), 32'h00005678);
    #2; rst = 0; mem_r = 0; mem_w = 0;
    #1;
    exp_rdval = '0;
    chk("arst we_n", 32'(we_n), 32'd1);
    chk("arst oe", 32'(oe), 32'd0);
    chk("arst ready", 32'(ready), 32'd1);
    chk("arst addr", 32'(saddr), 32'd0);
    chk("arst rdval", rdval, 32'd0);
    @(negedge clk); rst = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post ready", 32'(ready), 32'd1);
      chk("post we_n", 32'(we_n), 32'd1);
    end
    @(posedge clk); #1;
    access(0, 1, 0, 32'd1028, 32'h0, "post_load");

    access(1, 0, 1, 32'd1024, 32'hA5A55A5A, "w1_store");
    access(1, 1, 0, 32'd1024, 32'hA5A55A5A, "w1_load");
    access(1, 1, 0, 32'd1036, 32'h0, "w1_load_blank");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory stage of the five-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the execute-stage address (ALU result) and store data (Src2_Val), latched in the EXE/MEM pipeline register.
- Performs 32-bit loads/stores on an external 16-bit asynchronous SRAM through a wait-state FSM.
- Drives `ready` so the hazard/freeze logic stalls every pipeline register while an access is in flight.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles each 16-bit half-access is held on the SRAM bus; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- MEM_R_EN  input  1  load request, held until ready=1.
- MEM_W_EN  input  1  store request, held until ready=1.
- ALU_result  input  32  byte address from execute stage.
- Src2_Val  input  32  store data from execute stage.
- Mem_read_value  output  32  last completed load data.
- ready  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- SRAM_ADDR  output  18  SRAM halfword address.
- SRAM_DQ_OUT  output  16  write data to SRAM.
- SRAM_DQ_OE  output  1  1 = drive SRAM data bus (tristate enable at top level).
- SRAM_DQ_IN  input  16  read data from SRAM.
- SRAM_WE_N  output  1  active-low SRAM write enable.

Behaviour:
- Address mapping: offset = ALU_result - BASE_ADDR (32-bit wrap); word = offset[18:2]; offset[1:0] ignored.
  - Low half uses SRAM_ADDR = {word, 1'b0}; high half uses {word, 1'b1}.
  - No range check; upper bits are truncated.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A 4-bit counter cnt is cleared on every state change.
- IDLE:
  - If MEM_W_EN is set, go to WR_LO. Write has priority if MEM_R_EN and MEM_W_EN are both 1.
  - Else if MEM_R_EN is set, go to RD_LO.
  - Else stay in IDLE.
- RD_LO / RD_HI / WR_LO / WR_HI:
  - Stay while cnt < WAIT_CYCLES-1, incrementing cnt each cycle.
  - When cnt == WAIT_CYCLES-1, advance: RD_LO→RD_HI→DONE, WR_LO→WR_HI→DONE.
- DONE: unconditionally return to IDLE next cycle.
- ready (combinational):
  - 1 in IDLE with no request.
  - 1 in DONE.
  - 0 in IDLE with a request, and 0 in every access state.
  - The pipeline advances on the DONE edge, so IDLE next sees the following instruction and the same request is never replayed.
  - Stall length per access = 1 + 2*WAIT_CYCLES cycles of ready=0, then exactly 1 cycle of ready=1.
- Read:
  - At the last cycle of RD_LO, register SRAM_DQ_IN into lo_buf.
  - At the last cycle of RD_HI, register Mem_read_value <= {SRAM_DQ_IN, lo_buf}.
  - Mem_read_value is valid from DONE onward and holds until the next load completes; stores do not change it.
- Write:
  - WR_LO: SRAM_DQ_OUT = Src2_Val[15:0].
  - WR_HI: SRAM_DQ_OUT = Src2_Val[31:16].
  - SRAM_DQ_OE = 1 and SRAM_WE_N = 0 in both write states.
  - SRAM_WE_N returns to 1 in DONE.
- Outside write states: SRAM_DQ_OE = 0, SRAM_WE_N = 1, SRAM_DQ_OUT = 0.
- SRAM_ADDR is registered-path combinational from state and inputs; it is 0 in IDLE and DONE.
- Inputs must stay stable while ready=0. This is guaranteed by freeze; the block does not re-latch them.
- Reset (rst=0, any time, including mid-access):
  - state = IDLE, cnt = 0, lo_buf = 0, Mem_read_value = 0.
  - SRAM_WE_N = 1, SRAM_DQ_OE = 0, SRAM_ADDR = 0.
  - An interrupted write may leave the SRAM partially written; this is accepted.

Test Plan (WAIT_CYCLES=2, BASE_ADDR=1024):
1. Store: MEM_W_EN=1, ALU_result=1028, Src2_Val=0xDEADBEEF.
   - Required: ready=0 for 5 cycles, then 1 for one cycle.
   - SRAM halfword 2 = 0xBEEF, halfword 3 = 0xDEAD.
   - SRAM_WE_N low for exactly 4 cycles.
2. Load-back: MEM_R_EN=1, ALU_result=1028, SRAM model returns stored data.
   - Required: Mem_read_value = 0xDEADBEEF at DONE; ready=0 for 5 cycles.
   - SRAM_DQ_OE=0 throughout.
3. Idle / no-op: MEM_R_EN=MEM_W_EN=0 for 10 cycles.
   - Required: ready=1 constantly, SRAM_WE_N=1, Mem_read_value unchanged.
4. Back-to-back: load 1024 then store 1032 with requests held by a freeze model.
   - Required: each access stalls independently (5+1, 5+1 cycles).
   - No extra access is issued between them.
   - Mem_read_value is not altered by the store.
5. Conflict and reset: MEM_R_EN=MEM_W_EN=1 → a write is performed.
   - Drive rst=0 during WR_HI.
   - Required: SRAM_WE_N=1, SRAM_DQ_OE=0, ready=1, Mem_read_value=0 immediately (asynchronous).
   - After rst=1 with no request, state stays IDLE.
6. WAIT_CYCLES=1 build: load 1024.
   - Required: ready=0 for 3 cycles, then 1; both halves sampled correctly.
